// File: rtl/code_conv_arbiter.sv
// code_conv_arbiter: round-robin sharing of one registered binary/Gray converter among N_REQ requesters
module code_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int IDW = $clog2(N_REQ),
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_mode,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_mode,
  output logic [IDW-1:0]         out_id,
  output logic [CNTW-1:0]        conv_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gnt;
  logic [WIDTH-1:0] data_q, data_d, sel_data, conv;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d, sel_mode, any, can_load, load;
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        gnt = IDW'((int'(ptr_q) + k) % N_REQ);
        any = 1'b1;
      end
  end
  always_comb begin
    sel_data = req_data[int'(gnt) * WIDTH +: WIDTH];
    sel_mode = req_mode[gnt];
    conv = sel_data ^ (sel_data >> 1);
    if (sel_mode)
      for (int i = WIDTH - 2; i >= 0; i--) conv[i] = conv[i+1] ^ sel_data[i];
  end
  always_comb begin
    can_load = rst_n && (state_q == EMPTY || out_ready);
    load = can_load && any;
    req_ready = load ? N_REQ'(1) << gnt : '0;
    state_d = load ? FULL : (out_ready ? EMPTY : state_q);
    data_d = load ? conv : data_q;
    mode_d = load ? sel_mode : mode_q;
    id_d = load ? gnt : id_q;
    ptr_d = load ? (gnt == IDW'(N_REQ - 1) ? '0 : gnt + 1'b1) : ptr_q;
    cnt_d = cnt_q + CNTW'(load);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      mode_q <= 1'b0;
      id_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      mode_q <= mode_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = state_q == FULL;
  assign out_data = data_q;
  assign out_mode = mode_q;
  assign out_id = id_q;
  assign conv_count = cnt_q;
endmodule

// File: tb/tb_code_conv_arbiter.sv
// tb_code_conv_arbiter: directed stimulus checked each cycle against a behavioural model plus literal expectations
module tb_code_conv_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '1;
  logic [N-1:0] req_mode = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic out_mode;
  logic [1:0] out_id;
  logic [CW-1:0] conv_count;
  int n_checks = 0;
  int n_fail = 0;
  logic m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  logic m_mode = 1'b0;
  int m_id = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  code_conv_arbiter #(.N_REQ(N), .WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_mode(req_mode),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .out_id(out_id), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  always @(negedge clk) begin
    int gnt;
    int idx;
    logic [N-1:0] exp_ready;
    logic [W-1:0] d;
    gnt = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (gnt < 0 && req_valid[idx]) gnt = idx;
    end
    exp_ready = (rst_n && (!m_valid || out_ready) && gnt >= 0) ? N'(1) << gnt : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_mode", 32'(out_mode), 32'(m_mode));
    check("out_id", 32'(out_id), 32'(m_id));
    check("conv_count", 32'(conv_count), 32'(m_cnt));
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_mode = 1'b0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else if (exp_ready != '0) begin
      d = req_data[gnt*W +: W];
      m_mode = req_mode[gnt];
      m_data = m_mode ? from_gray(d) : to_gray(d);
      m_valid = 1'b1;
      m_id = gnt;
      m_ptr = (gnt + 1) % N;
      m_cnt = (m_cnt + 1) % (1 << CW);
    end else if (out_ready) m_valid = 1'b0;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic mode, input logic [W-1:0] data);
    req_mode[i] = mode;
    req_data[i*W +: W] = data;
  endtask

  initial begin
    logic [W-1:0] g;
    for (int i = 0; i < N; i++) set_req(i, 1'(i % 2), W'(i * 5 + 3));
    cyc(); cyc();
    #1;
    check("reset req_ready", 32'(req_ready), 0);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset conv_count", 32'(conv_count), 0);
    rst_n = 1'b1; req_valid = '0;
    cyc();
    req_valid = 4'b0100; set_req(2, 1'b0, 4'b0110);
    #1 check("single ready", 32'(req_ready), 32'b0100);
    cyc();
    check("single valid", 32'(out_valid), 1);
    check("single b2g 0110", 32'(out_data), 32'b0101);
    check("single id", 32'(out_id), 2);
    set_req(2, 1'b1, 4'b0101);
    cyc();
    check("single g2b 0101", 32'(out_data), 32'b0110);
    check("single mode", 32'(out_mode), 1);
    set_req(2, 1'b0, 4'b1011);
    cyc();
    check("single b2g 1011", 32'(out_data), 32'b1110);
    req_valid = '0;
    cyc();
    check("drain empty", 32'(out_valid), 0);
    check("drain keeps data", 32'(out_data), 32'b1110);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; req_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("rr id", 32'(out_id), 32'(k % N));
    end
    check("rr count", 32'(conv_count), 8);
    req_valid = 4'b0010;
    cyc();
    check("bp id1", 32'(out_id), 1);
    req_valid = 4'b1001; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp ready held", 32'(req_ready), 0);
      cyc();
      check("bp id stable", 32'(out_id), 1);
      check("bp valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1 check("bp grant 3 first", 32'(req_ready), 32'b1000);
    cyc();
    check("bp id3", 32'(out_id), 3);
    req_valid = 4'b0001;
    cyc();
    check("bp id0", 32'(out_id), 0);
    req_valid = '0;
    cyc();
    for (int v = 0; v < 16; v++) begin
      req_valid = N'(1) << (v % N);
      set_req(v % N, 1'b0, W'(v));
      cyc();
      g = out_data;
      check("rt id", 32'(out_id), 32'(v % N));
      set_req(v % N, 1'b1, g);
      cyc();
      check("rt roundtrip", 32'(out_data), 32'(v));
    end
    req_valid = '0;
    cyc();
    req_valid = 4'b0100; set_req(2, 1'b0, 4'b0011); out_ready = 1'b0;
    cyc();
    check("mid full", 32'(out_valid), 1);
    check("mid b2g 0011", 32'(out_data), 32'b0010);
    rst_n = 1'b0; req_valid = '1;
    #1 check("mid rst ready", 32'(req_ready), 0);
    cyc();
    check("mid rst valid", 32'(out_valid), 0);
    check("mid rst count", 32'(conv_count), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 check("mid rst grant 0", 32'(req_ready), 32'b0001);
    cyc();
    check("mid rst id0", 32'(out_id), 0);
    req_valid = 4'b0001;
    for (int k = 0; k < 16; k++) cyc();
    check("wrap count", 32'(conv_count), 1);
    req_valid = '0;
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
